// File: rtl/spi_master_param_if.sv
// Host handshake and SPI pin bundle for spi_master_param.
// The lsb_first signal exists only when SPI_MASTER_PARAM_LSB_FIRST_EN is defined.
interface spi_master_param_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 1,
    parameter int DIV_W    = 8,
    parameter int SS_SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
    logic                start;
    logic [DATA_W-1:0]   tx_data;
    logic [SS_SEL_W-1:0] ss_sel;
    logic [DIV_W-1:0]    clk_div;
    logic                cpol;
    logic                cpha;
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
    logic                lsb_first;
`endif
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   rx_data;
    logic                sclk;
    logic                mosi;
    logic                miso;
    logic [NUM_SS-1:0]   ss_n;

    // master: the SPI master block itself; slave: the host/pin environment.
    modport master (
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
        input  lsb_first,
`endif
        input  start, tx_data, ss_sel, clk_div, cpol, cpha, miso,
        output busy, done, rx_data, sclk, mosi, ss_n
    );

    modport slave (
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
        output lsb_first,
`endif
        output start, tx_data, ss_sel, clk_div, cpol, cpha, miso,
        input  busy, done, rx_data, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: single-word transfers, 4 CPOL/CPHA modes, programmable divider.
// Optional LSB-first support is enabled by defining SPI_MASTER_PARAM_LSB_FIRST_EN.
//
// state | meaning
// IDLE  | sclk follows cpol, waiting for start
// SETUP | ss_n asserted, H cycles before the first sclk edge
// XFER  | 2*DATA_W sclk edges, one every H cycles
// HOLD  | sclk at cpol for H cycles, then release ss_n and pulse done
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 1,
    parameter int DIV_W    = 8,
    parameter int SS_SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic clk,
    input  logic reset,
    spi_master_param_if.master bus
);
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    tmr_q, tmr_d, div_q, div_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                cpha_q, cpha_d, lsb_q, lsb_d;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;

    logic                lsb_in, tc, do_edge, odd_edge, sample_edge, shift_edge;
    logic [EW-1:0]       edge_nxt;
    logic                tx_bit, acc_bit;
    logic [DATA_W-1:0]   tx_shift, acc_rest, rx_shift;

`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_SEL_W-1:0] sel);
        ss_decode = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SS_SEL_W'(i)) ss_decode[i] = 1'b0;
        end
    endfunction

    assign tc       = (tmr_q == '0);
    assign edge_nxt = edge_q + EW'(1);
    assign odd_edge = edge_nxt[0];
    assign do_edge  = tc && ((state_q == SETUP) || (state_q == XFER && edge_q != LAST_EDGE));
    // Odd edges are leading: cpha=0 samples there, cpha=1 launches data there.
    assign sample_edge = cpha_q ? ~odd_edge : odd_edge;
    assign shift_edge  = cpha_q ? odd_edge : (~odd_edge && edge_nxt != LAST_EDGE);

    assign tx_bit   = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    assign tx_shift = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    assign acc_bit  = lsb_in ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
    assign acc_rest = lsb_in ? (bus.tx_data >> 1) : (bus.tx_data << 1);
    assign rx_shift = lsb_q ? {bus.miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], bus.miso};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ss_n_q    <= ss_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (tc) state_d = XFER;
            XFER:    if (tc && edge_q == LAST_EDGE) state_d = HOLD;
            HOLD:    if (tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_d     = tmr_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ss_n_d    = ss_n_q;
        case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                if (bus.start) begin
                    div_d  = bus.clk_div;
                    tmr_d  = bus.clk_div;
                    edge_d = '0;
                    cpha_d = bus.cpha;
                    lsb_d  = lsb_in;
                    busy_d = 1'b1;
                    ss_n_d = ss_decode(bus.ss_sel);
                    if (bus.cpha) begin
                        tx_sh_d = bus.tx_data;
                        mosi_d  = 1'b0;
                    end else begin
                        tx_sh_d = acc_rest;
                        mosi_d  = acc_bit;
                    end
                end
            end
            SETUP, XFER: begin
                tmr_d = tc ? div_q : tmr_q - DIV_W'(1);
                if (do_edge) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (sample_edge) rx_sh_d = rx_shift;
                    if (shift_edge) begin
                        mosi_d  = tx_bit;
                        tx_sh_d = tx_shift;
                    end
                end
            end
            HOLD: begin
                tmr_d = tc ? div_q : tmr_q - DIV_W'(1);
                if (tc) begin
                    ss_n_d    = '1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.ss_n    = ss_n_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param (DATA_W=8, NUM_SS=3).
// Stimulus pushes expected rx words; a monitor pops and compares on every done pulse.
module tb_spi_master_param;
    localparam logic [7:0] SLV_WORD = 8'h3C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loop = 1'b0;
    logic [7:0] slv_sh;
    logic [7:0] mosi_cap = 8'h00;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    logic sclk_prev = 1'b0;
    logic run_started = 1'b0;
    int run_len = 0;
    int exp_run = 4;
    int edges_seen = 0;
    int bad_runs = 0;

    spi_master_param_if #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) bus ();

    spi_master_param #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Mode-0 slave on ss_n[0]: MSB ready on select, shifts on falling sclk.
    assign bus.miso = loop ? bus.mosi : slv_sh[7];
    always @(negedge bus.sclk or posedge bus.ss_n[0]) begin
        if (bus.ss_n[0]) slv_sh <= SLV_WORD;
        else             slv_sh <= slv_sh << 1;
    end

    always @(posedge bus.sclk) mosi_cap <= {mosi_cap[6:0], bus.mosi};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done, rx_data=0x%0h", bus.rx_data);
            end else begin
                logic [7:0] exp;
                exp = sb_q.pop_front();
                check("rx_data", 32'(bus.rx_data), 32'(exp));
                check("busy_at_done", 32'(bus.busy), 32'd0);
                check("ss_n_at_done", 32'(bus.ss_n), 32'h7);
            end
        end
    end

    // sclk edge/level-length monitor while busy.
    always @(negedge clk) begin
        if (bus.busy) begin
            if (bus.sclk != sclk_prev) begin
                if (run_started && run_len != exp_run) bad_runs <= bad_runs + 1;
                edges_seen  <= edges_seen + 1;
                run_started <= 1'b1;
                run_len     <= 1;
            end else begin
                run_len <= run_len + 1;
            end
        end else begin
            run_started <= 1'b0;
        end
        sclk_prev <= bus.sclk;
    end

    task automatic xfer(input logic [7:0] tx, input logic [1:0] sel, input logic [7:0] div,
                        input logic pol, input logic pha, input logic lsb,
                        input logic [7:0] exp_rx, input int pulse_at);
        int k;
        logic [2:0] exp_ss;
        logic exp_m;
        @(negedge clk);
        bus.tx_data = tx;
        bus.ss_sel  = sel;
        bus.clk_div = div;
        bus.cpol    = pol;
        bus.cpha    = pha;
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
        bus.lsb_first = lsb;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        sb_q.push_back(exp_rx);
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        exp_ss = 3'b111;
        if (sel < 2'd3) exp_ss[sel] = 1'b0;
        exp_m = pha ? 1'b0 : (lsb ? tx[0] : tx[7]);
        check("busy_cycle1", 32'(bus.busy), 32'd1);
        check("ss_n_cycle1", 32'(bus.ss_n), 32'(exp_ss));
        check("mosi_cycle1", 32'(bus.mosi), 32'(exp_m));
        while (bus.done !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
            if (pulse_at != 0) begin
                bus.start   = (k == pulse_at);
                if (k == pulse_at) bus.tx_data = 8'hFF;
            end
        end
        bus.start = 1'b0;
        check("done_cycle", 32'(k), 32'(1 + 18 * (int'(div) + 1)));
        check("sclk_idle", 32'(bus.sclk), 32'(pol));
    endtask

    initial begin
        int e0, b0, k, gap;
        bus.start = 1'b0;
        bus.tx_data = 8'h00;
        bus.ss_sel = 2'd0;
        bus.clk_div = 8'd0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.sclk, bus.mosi, bus.ss_n, bus.busy, bus.done, bus.rx_data}),
              32'({1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00}));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0, external slave returning 0x3C.
        loop = 1'b0;
        xfer(8'hA5, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 0);
        check("mosi_bits", 32'(mosi_cap), 32'hA5);

        // All four modes, loopback, H=4.
        loop = 1'b1;
        exp_run = 4;
        for (int m = 0; m < 4; m++) begin
            e0 = edges_seen;
            b0 = bad_runs;
            xfer(8'h5A, 2'd0, 8'd3, m[1], m[0], 1'b0, 8'h5A, 0);
            check("sclk_edges", 32'(edges_seen - e0), 32'd16);
            check("sclk_level_len", 32'(bad_runs - b0), 32'd0);
        end

        // start held high: two back-to-back transfers.
        @(negedge clk);
        bus.tx_data = 8'h11; bus.ss_sel = 2'd0; bus.clk_div = 8'd0;
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h11);
        k = 0;
        while (bus.done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        gap = 0;
        while (bus.ss_n[0] && gap < 50) begin gap++; @(negedge clk); end
        check("ss_gap", 32'(gap), 32'd1);
        k = 1;
        while (bus.done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        bus.start = 1'b0;
        check("b2b_done_cycle", 32'(k), 32'd19);

        // start pulse mid-transfer ignored.
        xfer(8'h96, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h96, 5);

        // Slave selects.
        xfer(8'h3C, 2'd2, 8'd1, 1'b0, 1'b1, 1'b0, 8'h3C, 0);
        xfer(8'h81, 2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 8'h81, 0);

        // Reset at cycle 7 of a mode-2 transfer; no done may follow.
        @(negedge clk);
        bus.tx_data = 8'hC3; bus.ss_sel = 2'd0; bus.clk_div = 8'd0;
        bus.cpol = 1'b1; bus.cpha = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_ss_n", 32'(bus.ss_n), 32'h7);
        check("rst_mid_sclk", 32'(bus.sclk), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        bus.cpol = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        xfer(8'hC3, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'hC3, 0);

`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
        xfer(8'h01, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'h01, 0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
